// File: rtl/alu_decode_pkg.sv
// alu_decode_pkg: shared ALU control codes, data-processing cmd encodings,
// FlagW constants and the decode-stage state enum.
// Optional feature macro: ALU_MUL_EN (adds the MUL_BUSY state).
package alu_decode_pkg;

    // ALU control codes (4-bit native width; zero-extended to CTRL_W)
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_EOR   = 4'b0001;
    localparam logic [3:0] ALU_SUBAB = 4'b0010;
    localparam logic [3:0] ALU_SUBBA = 4'b0011;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_ADC   = 4'b0101;
    localparam logic [3:0] ALU_SBCAB = 4'b0110;
    localparam logic [3:0] ALU_SBCBA = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;
    localparam logic [3:0] ALU_ORR   = 4'b1100;
    localparam logic [3:0] ALU_MOV   = 4'b1101;
    localparam logic [3:0] ALU_BIC   = 4'b1110;
    localparam logic [3:0] ALU_MVN   = 4'b1111;

    // Data-processing cmd field encodings
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_RSB = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_SBC = 4'b0110;
    localparam logic [3:0] CMD_RSC = 4'b0111;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;
    localparam logic [3:0] CMD_MVN = 4'b1111;

    // FlagW: {NZ write, CV write}
    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_NZ   = 2'b10;
    localparam logic [1:0] FW_ALL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VALID    = 2'd1
`ifdef ALU_MUL_EN
        ,
        ST_MUL_BUSY = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb: pure combinational ALU decode table.
// Optional feature macro: ALU_MUL_EN (recognises MUL via i_mul_hint).
module alu_decode_comb
    import alu_decode_pkg::*;
#(
    parameter logic [23:0] BX_PATTERN = 24'h12FFF1
) (
    input  logic [1:0]  i_op,
    input  logic [4:0]  i_funct,
    input  logic        i_alu_op,
    input  logic        i_mul_hint,
    input  logic [23:0] i_bx_inst,
    output logic [3:0]  o_ctrl,
    output logic [1:0]  o_flag_w,
    output logic        o_no_write,
    output logic        o_illegal,
    output logic        o_is_mul
);

    logic [3:0] w_cmd;
    logic       w_s;

    assign w_cmd = i_funct[4:1];
    assign w_s   = i_funct[0];

`ifndef ALU_MUL_EN
    logic w_unused_mul_hint;
    assign w_unused_mul_hint = i_mul_hint;
`endif

    // Decode table: non-DP default / BX / MUL, then the 16 DP commands
    always_comb begin
        o_ctrl     = ALU_ADD;
        o_flag_w   = FW_NONE;
        o_no_write = 1'b0;
        o_illegal  = 1'b0;
        o_is_mul   = 1'b0;
        if (!i_alu_op) begin
`ifdef ALU_MUL_EN
            if (i_mul_hint) begin
                o_is_mul = 1'b1;
                o_ctrl   = ALU_MUL;
                o_flag_w = w_s ? FW_NZ : FW_NONE;
            end else
`endif
            if (i_op == 2'b00 && i_bx_inst == BX_PATTERN) begin
                o_ctrl = ALU_MOV;
            end
        end else begin
            case (w_cmd)
                CMD_AND: begin o_ctrl = ALU_AND;   o_flag_w = w_s ? FW_NZ  : FW_NONE; end
                CMD_EOR: begin o_ctrl = ALU_EOR;   o_flag_w = w_s ? FW_NZ  : FW_NONE; end
                CMD_SUB: begin o_ctrl = ALU_SUBAB; o_flag_w = w_s ? FW_ALL : FW_NONE; end
                CMD_RSB: begin o_ctrl = ALU_SUBBA; o_flag_w = w_s ? FW_ALL : FW_NONE; end
                CMD_ADD: begin o_ctrl = ALU_ADD;   o_flag_w = w_s ? FW_ALL : FW_NONE; end
                CMD_ADC: begin o_ctrl = ALU_ADC;   o_flag_w = w_s ? FW_ALL : FW_NONE; end
                CMD_SBC: begin o_ctrl = ALU_SBCAB; o_flag_w = w_s ? FW_ALL : FW_NONE; end
                CMD_RSC: begin o_ctrl = ALU_SBCBA; o_flag_w = w_s ? FW_ALL : FW_NONE; end
                CMD_TST, CMD_TEQ, CMD_CMP, CMD_CMN: begin
                    o_no_write = 1'b1;
                    if (!w_s) begin
                        // compare without S is meaningless: treat as flagless MOV
                        o_illegal = 1'b1;
                        o_ctrl    = ALU_MOV;
                    end else begin
                        case (w_cmd)
                            CMD_TST: begin o_ctrl = ALU_AND;   o_flag_w = FW_NZ;  end
                            CMD_TEQ: begin o_ctrl = ALU_EOR;   o_flag_w = FW_NZ;  end
                            CMD_CMP: begin o_ctrl = ALU_SUBAB; o_flag_w = FW_ALL; end
                            default: begin o_ctrl = ALU_ADD;   o_flag_w = FW_ALL; end
                        endcase
                    end
                end
                CMD_ORR: begin o_ctrl = ALU_ORR; o_flag_w = w_s ? FW_NZ : FW_NONE; end
                CMD_MOV: begin o_ctrl = ALU_MOV; o_flag_w = w_s ? FW_NZ : FW_NONE; end
                CMD_BIC: begin o_ctrl = ALU_BIC; o_flag_w = w_s ? FW_NZ : FW_NONE; end
                default: begin o_ctrl = ALU_MVN; o_flag_w = w_s ? FW_NZ : FW_NONE; end
            endcase
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered ALU decode stage between Decode and Execute,
// with valid/ready/stall/flush handshake.
// Optional feature macro: ALU_MUL_EN (multi-cycle MUL sequencing, busy).
module alu_decode_stage #(
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_LAT    = 3,
    parameter logic [23:0] BX_PATTERN = 24'h12FFF1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [4:0]        funct,
    input  logic              alu_op,
    input  logic              mul_hint,
    input  logic [23:0]       bx_inst,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_alu_ctrl,
    output logic [1:0]        out_flag_w,
    output logic              out_no_write,
    output logic              out_illegal,
    output logic              busy
);

    import alu_decode_pkg::*;

    logic [3:0] w_dec_ctrl;
    logic [1:0] w_dec_flag_w;
    logic       w_dec_no_write;
    logic       w_dec_illegal;
    logic       w_dec_is_mul;
    logic       w_accept;

    state_t            r_state, w_state_nxt;
    logic [CTRL_W-1:0] r_alu_ctrl, w_alu_ctrl_nxt;
    logic [1:0]        r_flag_w, w_flag_w_nxt;
    logic              r_no_write, w_no_write_nxt;
    logic              r_illegal, w_illegal_nxt;

`ifdef ALU_MUL_EN
    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`else
    localparam int unsigned unused_mul_lat = MUL_LAT;
    logic w_unused_is_mul;
    assign w_unused_is_mul = w_dec_is_mul;
`endif

    alu_decode_comb #(
        .BX_PATTERN (BX_PATTERN)
    ) u_dec (
        .i_op       (op),
        .i_funct    (funct),
        .i_alu_op   (alu_op),
        .i_mul_hint (mul_hint),
        .i_bx_inst  (bx_inst),
        .o_ctrl     (w_dec_ctrl),
        .o_flag_w   (w_dec_flag_w),
        .o_no_write (w_dec_no_write),
        .o_illegal  (w_dec_illegal),
        .o_is_mul   (w_dec_is_mul)
    );

    assign in_ready = !reset && !flush &&
                      (r_state == ST_IDLE || (r_state == ST_VALID && !stall));
    assign w_accept = in_valid && in_ready;

    // Next-state and next-output-register logic
    always_comb begin
        w_state_nxt    = r_state;
        w_alu_ctrl_nxt = r_alu_ctrl;
        w_flag_w_nxt   = r_flag_w;
        w_no_write_nxt = r_no_write;
        w_illegal_nxt  = r_illegal;
`ifdef ALU_MUL_EN
        w_cnt_nxt      = r_cnt;
`endif
        if (flush) begin
            w_state_nxt    = ST_IDLE;
            w_alu_ctrl_nxt = '0;
            w_flag_w_nxt   = '0;
            w_no_write_nxt = 1'b0;
            w_illegal_nxt  = 1'b0;
`ifdef ALU_MUL_EN
            w_cnt_nxt      = '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_VALID: begin
                    if (w_accept) begin
                        w_alu_ctrl_nxt = CTRL_W'(w_dec_ctrl);
                        w_flag_w_nxt   = w_dec_flag_w;
                        w_no_write_nxt = w_dec_no_write;
                        w_illegal_nxt  = w_dec_illegal;
`ifdef ALU_MUL_EN
                        if (w_dec_is_mul && (MUL_LAT > 1)) begin
                            w_state_nxt = ST_MUL_BUSY;
                            w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
                        end else
`endif
                        w_state_nxt = ST_VALID;
                    end else if (!(r_state == ST_VALID && stall)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL_BUSY: begin
                    // stall is deliberately ignored while counting down
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_VALID;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
`endif
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_alu_ctrl <= '0;
            r_flag_w   <= '0;
            r_no_write <= 1'b0;
            r_illegal  <= 1'b0;
`ifdef ALU_MUL_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_alu_ctrl <= w_alu_ctrl_nxt;
            r_flag_w   <= w_flag_w_nxt;
            r_no_write <= w_no_write_nxt;
            r_illegal  <= w_illegal_nxt;
`ifdef ALU_MUL_EN
            r_cnt      <= w_cnt_nxt;
`endif
        end
    end

    assign out_valid    = (r_state == ST_VALID);
    assign out_alu_ctrl = r_alu_ctrl;
    assign out_flag_w   = r_flag_w;
    assign out_no_write = r_no_write;
    assign out_illegal  = r_illegal;
`ifdef ALU_MUL_EN
    assign busy = (r_state == ST_MUL_BUSY);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: self-checking bench for alu_decode_stage.
// MUL sequencing checks run only when ALU_MUL_EN is defined.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, alu_op, mul_hint, stall, flush;
    logic [1:0]  op;
    logic [4:0]  funct;
    logic [23:0] bx_inst;
    logic        out_valid, out_no_write, out_illegal, busy;
    logic [3:0]  out_alu_ctrl;
    logic [1:0]  out_flag_w;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(
        .CTRL_W     (4),
        .MUL_LAT    (3),
        .BX_PATTERN (24'h12FFF1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .funct        (funct),
        .alu_op       (alu_op),
        .mul_hint     (mul_hint),
        .bx_inst      (bx_inst),
        .stall        (stall),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_alu_ctrl (out_alu_ctrl),
        .out_flag_w   (out_flag_w),
        .out_no_write (out_no_write),
        .out_illegal  (out_illegal),
        .busy         (busy)
    );

    // Reference decode straight from the instruction-set rules
    function automatic void ref_decode(input logic [1:0] iop, input logic [4:0] fn,
                                       input logic aop, input logic [23:0] bx,
                                       output logic [3:0] c, output logic [1:0] fw,
                                       output logic nw, output logic il);
        int tbl [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 4, 12, 13, 14, 15};
        int cmd = int'(fn[4:1]);
        bit s = fn[0];
        nw = 1'b0; il = 1'b0; fw = 2'd0;
        if (!aop) begin
            c = (iop == 2'd0 && bx == 24'h12FFF1) ? 4'd13 : 4'd4;
        end else if (cmd >= 8 && cmd <= 11) begin
            nw = 1'b1;
            if (!s) begin il = 1'b1; c = 4'd13; end
            else begin c = 4'(tbl[cmd]); fw = (cmd >= 10) ? 2'd3 : 2'd2; end
        end else begin
            c = 4'(tbl[cmd]);
            if (s) fw = (cmd >= 2 && cmd <= 7) ? 2'd3 : 2'd2;
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [4:0] f,
                         input logic a, input logic m, input logic [23:0] b);
        in_valid = v; op = o; funct = f; alu_op = a; mul_hint = m; bx_inst = b;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 2'd0, 5'd0, 1'b0, 1'b0, 24'd0);
        #1;
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        tick(); tick();
        n_total++;
        if ({out_valid, out_alu_ctrl, out_flag_w, out_no_write, out_illegal, busy} !== 10'd0) begin
            n_bad++; $display("FAIL reset_outs: got v%b c%h f%b nw%b il%b b%b want all 0",
                              out_valid, out_alu_ctrl, out_flag_w, out_no_write, out_illegal, busy);
        end
        in_valid = 1'b0; reset = 1'b0; #1;
        n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", in_ready); end
        tick();
    endtask

    // One-shot instruction, check registered result then the drop of out_valid
    task automatic one_shot(input string nm, input logic [1:0] o, input logic [4:0] f,
                            input logic a, input logic m, input logic [23:0] b,
                            input logic [3:0] ec, input logic [1:0] ef, input logic enw,
                            input logic eil);
        drive(1'b1, o, f, a, m, b);
        tick();
        in_valid = 1'b0;
        n_total++;
        if ({out_valid, out_alu_ctrl, out_flag_w, out_no_write, out_illegal, busy} !==
            {1'b1, ec, ef, enw, eil, 1'b0}) begin
            n_bad++; $display("FAIL %s: got v%b c%h f%b nw%b il%b b%b want v1 c%h f%b nw%b il%b b0",
                              nm, out_valid, out_alu_ctrl, out_flag_w, out_no_write, out_illegal, busy,
                              ec, ef, enw, eil);
        end
        tick();
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_drop: got %b want 0", nm, out_valid); end
    endtask

    task automatic test_decode();
        one_shot("add_s",  2'd0, {4'b0100, 1'b1}, 1'b1, 1'b0, 24'd0,       4'b0100, 2'b11, 1'b0, 1'b0);
        one_shot("cmp_s0", 2'd0, {4'b1010, 1'b0}, 1'b1, 1'b0, 24'd0,       4'b1101, 2'b00, 1'b1, 1'b1);
        one_shot("tst_s",  2'd0, {4'b1000, 1'b1}, 1'b1, 1'b0, 24'd0,       4'b0000, 2'b10, 1'b1, 1'b0);
        one_shot("bx_hit", 2'd0, 5'd0,            1'b0, 1'b0, 24'h12FFF1,  4'b1101, 2'b00, 1'b0, 1'b0);
        one_shot("bx_miss",2'd0, 5'd0,            1'b0, 1'b0, 24'h12FFF0,  4'b0100, 2'b00, 1'b0, 1'b0);
        one_shot("bx_op1", 2'd1, 5'd0,            1'b0, 1'b0, 24'h12FFF1,  4'b0100, 2'b00, 1'b0, 1'b0);
        one_shot("mvn_s",  2'd0, {4'b1111, 1'b1}, 1'b1, 1'b0, 24'd0,       4'b1111, 2'b10, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        drive(1'b1, 2'd0, {4'b1100, 1'b1}, 1'b1, 1'b0, 24'd0);
        tick();
        drive(1'b1, 2'd0, {4'b0100, 1'b0}, 1'b1, 1'b0, 24'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
            n_total++;
            if ({out_valid, out_alu_ctrl, out_flag_w} !== {1'b1, 4'b1100, 2'b10}) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got v%b c%h f%b want v1 c c f10", i, out_valid, out_alu_ctrl, out_flag_w);
            end
            tick();
        end
        stall = 1'b0; #1;
        n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_total++;
        if ({out_valid, out_alu_ctrl, out_flag_w} !== {1'b1, 4'b0100, 2'b00}) begin
            n_bad++; $display("FAIL stall_next: got v%b c%h f%b want v1 c4 f00", out_valid, out_alu_ctrl, out_flag_w);
        end
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        tick();
        reset = 1'b1; #1;
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 0", in_ready); end
        tick();
        n_total++;
        if ({out_valid, out_alu_ctrl, out_flag_w, out_no_write, out_illegal, busy} !== 10'd0) begin
            n_bad++; $display("FAIL rst_mid_outs: got v%b c%h f%b want all 0", out_valid, out_alu_ctrl, out_flag_w);
        end
        reset = 1'b0; stall = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 2'd0, {4'b0101, 1'b1}, 1'b1, 1'b0, 24'd0);
        tick();
        drive(1'b1, 2'd0, {4'b0010, 1'b1}, 1'b1, 1'b0, 24'd0);
        flush = 1'b1; #1;
        n_total++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_mul();
`ifdef ALU_MUL_EN
        drive(1'b1, 2'd0, 5'd1, 1'b0, 1'b1, 24'h000090);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            n_total++;
            if ({busy, out_valid, in_ready} !== 3'b100) begin
                n_bad++; $display("FAIL mul_busy[%0d]: got b%b v%b r%b want b1 v0 r0", c, busy, out_valid, in_ready);
            end
            tick();
        end
        n_total++;
        if ({busy, out_valid, out_alu_ctrl, out_flag_w} !== {1'b0, 1'b1, 4'b1000, 2'b10}) begin
            n_bad++; $display("FAIL mul_done: got b%b v%b c%h f%b want b0 v1 c8 f10", busy, out_valid, out_alu_ctrl, out_flag_w);
        end
        tick();
        drive(1'b1, 2'd0, 5'd0, 1'b0, 1'b1, 24'h000090);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_total++;
        if ({busy, out_valid} !== 2'b00) begin n_bad++; $display("FAIL mul_flush: got b%b v%b want b0 v0", busy, out_valid); end
        tick();
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mul_flush_after: got %b want 0", out_valid); end
`else
        // without the feature a MUL is just the non-DP default
        one_shot("mul_off", 2'd0, 5'd1, 1'b0, 1'b1, 24'h000090, 4'b0100, 2'b00, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_random();
        logic       m_valid = 1'b0;
        logic [3:0] m_c = '0, c;
        logic [1:0] m_f = '0, f;
        logic       m_nw = 1'b0, m_il = 1'b0, nw, il, exp_ready;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), 5'($urandom), 1'($urandom),
`ifdef ALU_MUL_EN
                  1'b0,
`else
                  1'($urandom),
`endif
                  ($urandom_range(0, 3) == 0) ? 24'h12FFF1 : 24'($urandom));
            stall = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 19) == 0);
            #1;
            exp_ready = !flush && (!m_valid || !stall);
            n_total++;
            if (in_ready !== exp_ready) begin
                n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, in_ready, exp_ready);
            end
            if (flush) m_valid = 1'b0;
            else if (m_valid && stall) m_valid = 1'b1;
            else if (in_valid) begin
                ref_decode(op, funct, alu_op, bx_inst, c, f, nw, il);
                m_valid = 1'b1; m_c = c; m_f = f; m_nw = nw; m_il = il;
            end else m_valid = 1'b0;
            tick();
            n_total++;
            if (out_valid !== m_valid || busy !== 1'b0 ||
                (m_valid && {out_alu_ctrl, out_flag_w, out_no_write, out_illegal} !== {m_c, m_f, m_nw, m_il})) begin
                n_bad++; $display("FAIL rnd_out[%0d]: got v%b c%h f%b nw%b il%b b%b want v%b c%h f%b nw%b il%b b0",
                                  cyc, out_valid, out_alu_ctrl, out_flag_w, out_no_write, out_illegal, busy,
                                  m_valid, m_c, m_f, m_nw, m_il);
            end
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 24'd0);
        stall = 1'b0; flush = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_stall();
        test_reset_mid();
        test_flush();
        test_mul();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered, parametrised successor to the single-cycle ALU decoder in the pipelined ARM core; sits between the Decode and Execute pipeline registers.
- Decodes all 16 data-processing commands, plus BX and the non-DP default.
- Produces registered ALU control, FlagW and a register-write suppress bit.
- Uses a valid/ready/stall/flush handshake and sequences a multi-cycle MUL when enabled.

Parameters:
- CTRL_W, 4, ALU control output width (>=4; codes zero-extended).
- MUL_LAT, 3, cycles from MUL accept to out_valid (>=1).
- BX_PATTERN, 24'h12FFF1, instruction bits [23:0] identifying BX.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode-stage instruction present
- in_ready  out  1  stage can accept this cycle (combinational)
- op  in  2  instruction op field
- funct  in  5  {cmd[3:0], S}
- alu_op  in  1  1 = data-processing instruction
- mul_hint  in  1  instruction is MUL (op=00, bits[7:4]=1001)
- bx_inst  in  24  instruction bits [23:0]
- stall  in  1  Execute cannot take output; hold
- flush  in  1  discard held/in-flight instruction
- out_valid  out  1  outputs below are meaningful
- out_alu_ctrl  out  CTRL_W  ALU control code
- out_flag_w  out  2  {NZ write, CV write}
- out_no_write  out  1  suppress RegWrite (TST/TEQ/CMP/CMN)
- out_illegal  out  1  compare with S=0 (decoded as MOV, no flags, no write)
- busy  out  1  MUL sequencing in progress

Behaviour:
- Reset: state=IDLE, counter=0, all out_* = 0, busy=0; in_ready=0 while reset is high.
- ALU codes:
  - AND=0000, EOR=0001, SUBab=0010, SUBba=0011, ADD=0100, ADC=0101, SBCab=0110, SBCba=0111.
  - ORR=1100, MOV=1101, BIC=1110, MVN=1111, MUL=1000.
- alu_op=0: flag_w=00, no_write=0.
  - If op=00 and bx_inst==BX_PATTERN, ctrl=MOV; otherwise ctrl=ADD.
- alu_op=1, by cmd:
  - Arithmetic (0010–0111, 0100 ADD): ctrl per code table; flag_w = S ? 11 : 00.
  - Logical AND/EOR/ORR/MOV/BIC/MVN: flag_w = S ? 10 : 00.
  - TST(1000)→AND, TEQ(1001)→EOR: flag_w=10, no_write=1.
  - CMP(1010)→SUBab, CMN(1011)→ADD: flag_w=11, no_write=1.
  - Compare with S=0: illegal=1, ctrl=MOV, flag_w=00, no_write=1.
- States:
  - IDLE: out_valid=0.
  - VALID: out_valid=1.
  - MUL_BUSY: out_valid=0, busy=1.
- in_ready = !reset & !flush & (IDLE | (VALID & !stall)).
- Accept (in_valid & in_ready) of a non-MUL instruction: outputs registered, VALID next cycle. Latency is 1; back-to-back accepts are allowed.
- Accept of a MUL (mul_hint & alu_op=0) with MUL_LAT>1:
  - ctrl=MUL, flag_w = S ? 10 : 00.
  - Go to MUL_BUSY with counter=MUL_LAT-1, decrement each cycle.
  - At counter==1, move to VALID; out_valid rises exactly MUL_LAT cycles after accept.
  - MUL_LAT=1 behaves as single-cycle.
- VALID & stall: all outputs held bit-stable.
- VALID & !stall & !in_valid: IDLE next cycle.
- flush: highest priority after reset. Next cycle is IDLE with out_valid=0, counter=0, busy=0, and no accept in the flush cycle.
- reset mid-MUL: same as flush; all outputs cleared.
- stall is ignored during MUL_BUSY (countdown continues); stall then applies once VALID.

Optional Feature:
- ALU_MUL_EN:
  - Defined: MUL sequencing as above.
  - Undefined: mul_hint ignored; MUL_BUSY state, counter and busy logic removed; busy tied 0; MUL instructions decode as the alu_op=0 default (ADD, single-cycle).

Decomposition:
- Package alu_decode_pkg holds:
  - the ALU control code constants;
  - cmd encodings (CMD_AND..CMD_MVN);
  - FlagW constants (FW_NONE=00, FW_NZ=10, FW_ALL=11);
  - the state enum.
- Sub-module alu_decode_comb: the pure combinational decode table (op, funct, alu_op, mul_hint, bx_inst → ctrl, flag_w, no_write, illegal, is_mul), instantiated once. The parent holds the FSM, counter and output registers.

Test Plan:
- ADD with S=1 (cmd 0100), in_valid for one cycle, stall=0 → next cycle out_valid=1, ctrl=0100, flag_w=11, no_write=0; the cycle after, out_valid=0.
- CMP with S=0 → illegal=1, ctrl=1101, flag_w=00, no_write=1. TST with S=1 → ctrl=0000, flag_w=10, no_write=1.
- BX: op=00, alu_op=0, bx_inst=24'h12FFF1 → ctrl=1101. Same with bx_inst=24'h12FFF0 → ctrl=0100.
- Stall: accept ORR with S=1, hold stall=1 for 3 cycles with a new in_valid → outputs stable (1100/10), in_ready=0; on release, next instruction accepted the same cycle.
- ALU_MUL_EN, MUL_LAT=3: accept MUL at cycle 0 → busy=1 in cycles 1–2, in_ready=0, out_valid=1 with ctrl=1000 at cycle 3. Rerun with flush at cycle 1 → cycle 2 IDLE, busy=0, out_valid stays 0.
- Reset asserted while VALID & stall=1 → next cycle all outputs 0, state IDLE, in_ready=0 during reset.
